// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: state encoding and default sizing for bus_arbiter_2
package bus_arbiter_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OWN1 = 2'b01,
    OWN2 = 2'b10
  } state_t;
  localparam int MAX_HOLD_DEF   = 16;
  localparam int COUNT_BITS_DEF = 5;
endpackage

// File: rtl/bus_arbiter_2_hold_counter.sv
// hold_counter: saturating grant-length counter with terminal match at MaxHold-1
module hold_counter #(
  parameter int MaxHold   = 16,
  parameter int CountBits = 5
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic match
);
  logic [CountBits-1:0] count_q, count_d;
  // clear wins over count; count stops at all-ones
  always_comb count_d = clr ? '0 : (en && count_q != '1) ? count_q + 1'b1 : count_q;
  // count register
  always_ff @(posedge clock) count_q <= reset ? '0 : count_d;
  assign match = count_q == CountBits'(MaxHold - 1);
endmodule

// File: rtl/bus_arbiter_2.sv
// bus_arbiter_2: two-master round-robin arbiter, optional hold timeout under ARB_TIMEOUT_EN
module bus_arbiter_2
  import bus_arbiter_pkg::*;
#(
  parameter logic [1:0] RequestMask = 2'b00,
  parameter int         MaxHold     = MAX_HOLD_DEF,
  parameter int         CountBits   = COUNT_BITS_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic Req_1,
  input  logic Req_2,
  input  logic Done_1,
  input  logic Done_2,
  output logic Gnt_1,
  output logic Gnt_2,
  output logic Busy,
  output logic Owner,
  output logic Timeout
);
  state_t state_q, state_d;
  logic owner_q, owner_d, timeout_q, timeout_d;
  logic r1, r2, rel, tmatch;
  // next state: release hands over if the other master waits, else re-grant or idle
  always_comb begin
    r1 = Req_1 ^ RequestMask[0];
    r2 = Req_2 ^ RequestMask[1];
    rel = (state_q == OWN1 && (Done_1 || !r1)) || (state_q == OWN2 && (Done_2 || !r2));
    case (state_q)
      OWN1:    state_d = rel ? (r2 ? OWN2 : r1 ? OWN1 : IDLE) : (tmatch && r2) ? OWN2 : OWN1;
      OWN2:    state_d = rel ? (r1 ? OWN1 : r2 ? OWN2 : IDLE) : (tmatch && r1) ? OWN1 : OWN2;
      default: state_d = (r1 && r2) ? (owner_q ? OWN1 : OWN2) : r1 ? OWN1 : r2 ? OWN2 : IDLE;
    endcase
    timeout_d = state_q != IDLE && !rel && state_d != state_q;
    owner_d = state_d == OWN1 ? 1'b0 : state_d == OWN2 ? 1'b1 : owner_q;
  end
  // state, owner and timeout registers
  always_ff @(posedge clock) begin
    state_q   <= reset ? IDLE : state_d;
    owner_q   <= reset ? 1'b1 : owner_d;
    timeout_q <= reset ? 1'b0 : timeout_d;
  end
`ifdef ARB_TIMEOUT_EN
  logic clr;
  assign clr = state_d != IDLE && (state_d != state_q || rel);
  hold_counter #(.MaxHold(MaxHold), .CountBits(CountBits)) u_hold (
    .clock (clock),
    .reset (reset),
    .clr   (clr),
    .en    (state_q != IDLE),
    .match (tmatch)
  );
`else
  assign tmatch = 1'b0;
`endif
  assign Gnt_1   = state_q == OWN1;
  assign Gnt_2   = state_q == OWN2;
  assign Busy    = Gnt_1 | Gnt_2;
  assign Owner   = owner_q;
  assign Timeout = timeout_q;
endmodule

// File: tb/tb_bus_arbiter_2.sv
// tb_bus_arbiter_2: model-checked directed bench for bus_arbiter_2 (ARB_TIMEOUT_EN optional)
module tb_bus_arbiter_2;
  localparam int MH = 4;
  localparam int CB = 5;
`ifdef ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clock = 1'b0, reset = 1'b1;
  logic Req_1 = 0, Req_2 = 0, Done_1 = 0, Done_2 = 0;
  logic [4:0] outs [2];
  logic ag1, ag2, abusy, aown, ato, bg1, bg2, bbusy, bown, bto;
  int compared = 0, mismatched = 0;
  bit active = 0;
  always #5 clock = ~clock;

  bus_arbiter_2 #(.RequestMask(2'b00), .MaxHold(MH), .CountBits(CB)) u_a (
    .clock(clock), .reset(reset), .Req_1(Req_1), .Req_2(Req_2), .Done_1(Done_1), .Done_2(Done_2),
    .Gnt_1(ag1), .Gnt_2(ag2), .Busy(abusy), .Owner(aown), .Timeout(ato));
  bus_arbiter_2 #(.RequestMask(2'b10), .MaxHold(MH), .CountBits(CB)) u_b (
    .clock(clock), .reset(reset), .Req_1(Req_1), .Req_2(Req_2), .Done_1(Done_1), .Done_2(Done_2),
    .Gnt_1(bg1), .Gnt_2(bg2), .Busy(bbusy), .Owner(bown), .Timeout(bto));
  assign outs[0] = {ag1, ag2, abusy, aown, ato};
  assign outs[1] = {bg1, bg2, bbusy, bown, bto};

  // model: holder 0 = nobody, 1 or 2 = that master; last = index of last owner
  int holder [2], last [2], held [2];
  bit tpulse [2];
  always @(posedge clock) begin
    for (int i = 0; i < 2; i++) begin
      bit [1:0] m;
      bit e [3];
      bit d [3];
      int nxt, oth;
      bit entered;
      m = (i == 0) ? 2'b00 : 2'b10;
      e[1] = Req_1 ^ m[0];
      e[2] = Req_2 ^ m[1];
      d[1] = Done_1;
      d[2] = Done_2;
      if (reset) begin
        holder[i] = 0; last[i] = 2; held[i] = 0; tpulse[i] = 0;
      end else begin
        tpulse[i] = 0;
        nxt = holder[i];
        entered = 0;
        if (holder[i] == 0) begin
          if (e[1] && e[2]) nxt = 3 - last[i];
          else if (e[1]) nxt = 1;
          else if (e[2]) nxt = 2;
          entered = nxt != 0;
        end else begin
          oth = 3 - holder[i];
          if (d[holder[i]] || !e[holder[i]]) begin
            nxt = e[oth] ? oth : (e[holder[i]] ? holder[i] : 0);
            entered = nxt != 0;
          end else if (TO_EN && held[i] == MH - 1 && e[oth]) begin
            nxt = oth; tpulse[i] = 1; entered = 1;
          end
        end
        if (entered) begin
          held[i] = 0; last[i] = nxt;
        end else if (holder[i] != 0 && held[i] < (1 << CB) - 1) held[i]++;
        holder[i] = nxt;
      end
    end
  end

  // every-cycle comparison of both instances against the model
  always @(negedge clock) if (active) for (int i = 0; i < 2; i++) begin
    logic [4:0] exp;
    exp = {holder[i] == 1, holder[i] == 2, holder[i] != 0, last[i] == 2, tpulse[i]};
    compared++;
    if (outs[i] !== exp) begin
      mismatched++;
      $display("FAIL model[%0d] t=%0t got g1g2busyownto=%b want %b", i, $time, outs[i], exp);
    end
  end

  task automatic chk(input string name, input logic act, input logic exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s t=%0t got %b want %b", name, $time, act, exp);
    end
  endtask

  task automatic cyc(input logic r1, input logic r2, input logic d1, input logic d2, input logic rst);
    Req_1 = r1; Req_2 = r2; Done_1 = d1; Done_2 = d2; reset = rst;
    @(posedge clock); #1;
  endtask

  initial begin
    bit held_ok, to_seen;
    cyc(0, 0, 0, 0, 1);
    active = 1;
    cyc(0, 0, 0, 0, 1);
    chk("rst_gnt1", ag1, 0); chk("rst_gnt2", ag2, 0); chk("rst_busy", abusy, 0);
    chk("rst_owner", aown, 1); chk("rst_timeout", ato, 0);
    cyc(1, 0, 0, 0, 0);
    chk("single_gnt1", ag1, 1); chk("single_owner", aown, 0);
    cyc(0, 0, 1, 0, 0);
    chk("release_gnt1", ag1, 0); chk("release_busy", abusy, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 1, 0, 0);
    chk("regrant_gnt1", ag1, 1);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0);
    chk("contend_gnt1", ag1, 1); chk("contend_gnt2", ag2, 0);
    cyc(1, 1, 1, 0, 0);
    chk("handover_gnt1", ag1, 0); chk("handover_gnt2", ag2, 1); chk("handover_owner", aown, 1);
    cyc(1, 1, 0, 1, 0);
    chk("back_gnt1", ag1, 1); chk("back_gnt2", ag2, 0);
    cyc(0, 0, 1, 0, 0);
    chk("idle_busy", abusy, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
    chk("mask_gnt2", bg2, 1);
    cyc(0, 1, 0, 0, 0);
    chk("mask_drop_gnt2", bg2, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(1, 1, 0, 0, 0);
    chk("hold_start_gnt1", ag1, 1);
    if (TO_EN) begin
      for (int k = 0; k < MH - 1; k++) cyc(1, 1, 0, 0, 0);
      chk("pre_to_gnt1", ag1, 1); chk("pre_to_timeout", ato, 0);
      cyc(1, 1, 0, 0, 0);
      chk("to_gnt2", ag2, 1); chk("to_gnt1", ag1, 0); chk("to_pulse", ato, 1);
      cyc(1, 1, 0, 0, 0);
      chk("to_pulse_end", ato, 0);
    end else begin
      held_ok = 1;
      for (int k = 0; k < 40; k++) begin
        cyc(1, 1, 0, 0, 0);
        held_ok &= ag1 & ~ato;
      end
      chk("notimeout_hold40", held_ok, 1);
    end
    cyc(0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0);
    held_ok = 1; to_seen = 0;
    for (int k = 0; k < 40; k++) begin
      cyc(1, 0, 0, 0, 0);
      held_ok &= ag1;
      to_seen |= ato;
    end
    chk("solo_hold40", held_ok, 1); chk("solo_no_timeout", to_seen, 0);
    cyc(0, 0, 0, 0, 1);
    cyc(0, 1, 0, 0, 0);
    chk("pre_rst_gnt2", ag2, 1);
    cyc(1, 1, 0, 0, 1);
    chk("midrst_gnt1", ag1, 0); chk("midrst_gnt2", ag2, 0); chk("midrst_owner", aown, 1);
    cyc(1, 1, 0, 0, 0);
    chk("post_rst_gnt1", ag1, 1);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
